// File: rtl/rr_arb2_sel.sv
// rtl/rr_arb2_sel.sv - two-channel round-robin arbiter with burst hold and registered output stage
module rr_arb2_sel #(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    localparam int CW = $clog2(BURST_LEN) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic stall;
    logic a_acc, b_acc;
    logic cur_valid, cur_acc, oth_valid;
    logic oth_is_b;

    // Readies come only from registered state and the output-stage stall
    always_comb begin
        stall   = out_valid_q & ~out_ready;
        a_ready = (state_q == GNT_A) & ~stall;
        b_ready = (state_q == GNT_B) & ~stall;
        a_acc   = a_valid & a_ready;
        b_acc   = b_valid & b_ready;
    end

    // Next-state: grant selection, burst counting and the round-robin pointer
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        oth_is_b  = (state_q == GNT_A);
        cur_valid = oth_is_b ? a_valid : b_valid;
        cur_acc   = oth_is_b ? a_acc   : b_acc;
        oth_valid = oth_is_b ? b_valid : a_valid;
        case (state_q)
            IDLE: begin
                if (a_valid && b_valid) begin
                    state_d = ptr_q ? GNT_B : GNT_A;
                end else if (a_valid) begin
                    state_d = GNT_A;
                end else if (b_valid) begin
                    state_d = GNT_B;
                end
            end
            GNT_A, GNT_B: begin
                if (cur_acc && (cnt_q == CNT_LAST)) begin
                    cnt_d = '0;
                    ptr_d = oth_is_b;
                    if (oth_valid) begin
                        state_d = oth_is_b ? GNT_B : GNT_A;
                    end
                end else if (!cur_valid) begin
                    cnt_d   = '0;
                    ptr_d   = oth_is_b;
                    state_d = oth_valid ? (oth_is_b ? GNT_B : GNT_A) : IDLE;
                end else if (cur_acc) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        sel_d = (state_d == GNT_B);
    end

    // Output stage: capture the accepted beat, drain it when downstream takes it
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (a_acc) begin
            out_data_d  = a_data;
            out_valid_d = 1'b1;
        end else if (b_acc) begin
            out_data_d  = b_data;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers; reset drops any held beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            cnt_q       <= '0;
            sel_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign sel       = sel_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_rr_arb2_sel.sv
// tb/tb_rr_arb2_sel.sv - randomized and directed bench for rr_arb2_sel against a grant-level model
module tb_rr_arb2_sel;

    logic       clk;
    logic       rst_n;
    logic       v    [2][2];
    logic [7:0] dat  [2][2];
    logic       ordy [2];
    logic       ar   [2];
    logic       br   [2];
    logic       sl   [2];
    logic       ov   [2];
    logic [7:0] od   [2];

    int n_cmp = 0;
    int n_bad = 0;

    // model: grant 0=none 1=A 2=B, preferred channel, beats in current burst
    int         mg     [2];
    int         mpref  [2];
    int         mbeats [2];
    logic       m_ov   [2];
    logic [7:0] m_od   [2];
    bit         lacc   [2][2];
    int         seq    [2][2];

    rr_arb2_sel #(.WIDTH(8), .BURST_LEN(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(v[0][0]), .a_data(dat[0][0]), .a_ready(ar[0]),
        .b_valid(v[0][1]), .b_data(dat[0][1]), .b_ready(br[0]),
        .sel(sl[0]), .out_valid(ov[0]), .out_data(od[0]), .out_ready(ordy[0])
    );

    rr_arb2_sel #(.WIDTH(8), .BURST_LEN(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(v[1][0]), .a_data(dat[1][0]), .a_ready(ar[1]),
        .b_valid(v[1][1]), .b_data(dat[1][1]), .b_ready(br[1]),
        .sel(sl[1]), .out_valid(ov[1]), .out_data(od[1]), .out_ready(ordy[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string name, input int d, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, d, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mg[d] = 0; mpref[d] = 0; mbeats[d] = 0;
            m_ov[d] = 1'b0; m_od[d] = 8'h00;
            for (int c = 0; c < 2; c++) begin
                lacc[d][c] = 1'b0;
                v[d][c]    = 1'b0;
            end
            ordy[d] = 1'b0;
        end
    endtask

    task automatic check_dut(input int d);
        logic stall;
        stall = m_ov[d] && !ordy[d];
        cmp("a_ready",   d, 8'(ar[d]), 8'((mg[d] == 1) && !stall));
        cmp("b_ready",   d, 8'(br[d]), 8'((mg[d] == 2) && !stall));
        cmp("sel",       d, 8'(sl[d]), 8'(mg[d] == 2));
        cmp("out_valid", d, 8'(ov[d]), 8'(m_ov[d]));
        cmp("out_data",  d, od[d], m_od[d]);
    endtask

    // advance the model across the next rising edge using the inputs now applied
    task automatic model_step(input int d);
        int   bl;
        int   cur;
        int   oth;
        bit   acc;
        logic stall;
        bl    = (d == 0) ? 4 : 1;
        stall = m_ov[d] && !ordy[d];
        cur   = 0;
        oth   = 1;
        acc   = 1'b0;
        lacc[d][0] = 1'b0;
        lacc[d][1] = 1'b0;
        if (mg[d] != 0) begin
            cur = mg[d] - 1;
            oth = 1 - cur;
            acc = v[d][cur] && !stall;
        end
        if (acc) begin
            m_od[d] = dat[d][cur];
            m_ov[d] = 1'b1;
            lacc[d][cur] = 1'b1;
        end else if (ordy[d]) begin
            m_ov[d] = 1'b0;
        end
        if (mg[d] == 0) begin
            if (v[d][0] && v[d][1]) mg[d] = mpref[d] + 1;
            else if (v[d][0])       mg[d] = 1;
            else if (v[d][1])       mg[d] = 2;
        end else if (acc && (mbeats[d] + 1 == bl)) begin
            mbeats[d] = 0;
            mpref[d]  = oth;
            if (v[d][oth]) mg[d] = oth + 1;
        end else if (!v[d][cur]) begin
            mbeats[d] = 0;
            mpref[d]  = oth;
            mg[d]     = v[d][oth] ? oth + 1 : 0;
        end else if (acc) begin
            mbeats[d]++;
        end
    endtask

    // mode 0 random sources, 1 A-only 6 beats from 0x10, 2 both always valid, 3 A gives 2 beats then drops
    task automatic do_cycle(input int mode, input logic ordy_in);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 2; c++) begin
                if (lacc[d][c]) seq[d][c]++;
            end
            case (mode)
                1: begin v[d][0] = (seq[d][0] < 6); v[d][1] = 1'b0; end
                2: begin v[d][0] = 1'b1; v[d][1] = 1'b1; end
                3: begin v[d][0] = (seq[d][0] < 2); v[d][1] = 1'b1; end
                default: begin
                    for (int c = 0; c < 2; c++) begin
                        if (v[d][c] && !lacc[d][c]) v[d][c] = ($urandom_range(0, 9) != 0);
                        else                        v[d][c] = ($urandom_range(0, 1) != 0);
                    end
                end
            endcase
            dat[d][0] = (mode == 1) ? 8'h10 + 8'(seq[d][0]) : {1'b0, 7'(seq[d][0])};
            dat[d][1] = {1'b1, 7'(seq[d][1])};
            ordy[d]   = ordy_in;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            check_dut(d);
            model_step(d);
        end
    endtask

    initial begin
        logic       sel_h [20];
        logic [7:0] od1_h [20];
        logic [7:0] held;
        int         i0;

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 2; c++) begin
                seq[d][c] = 0;
                dat[d][c] = 8'h00;
            end
        end
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            cmp("rst_sel",       d, 8'(sl[d]), 8'h00);
            cmp("rst_out_valid", d, 8'(ov[d]), 8'h00);
            cmp("rst_out_data",  d, od[d],     8'h00);
            cmp("rst_a_ready",   d, 8'(ar[d]), 8'h00);
            cmp("rst_b_ready",   d, 8'(br[d]), 8'h00);
        end
        rst_n = 1'b1;

        // single source A streams 0x10..0x15
        for (int k = 1; k <= 12; k++) begin
            do_cycle(1, 1'b1);
            cmp("single_sel", 0, 8'(sl[0]), 8'h00);
            if (k == 2) cmp("single_first_ready", 0, 8'(ar[0]), 8'h01);
            if (k == 3) cmp("single_first_beat", 0, od[0], 8'h10);
            if (k == 8) cmp("single_last_beat",  0, od[0], 8'h15);
            if (k == 8) cmp("single_last_beat",  1, od[1], 8'h15);
        end

        // contention: both always valid
        for (int k = 0; k < 20; k++) begin
            do_cycle(2, 1'b1);
            sel_h[k] = sl[0];
            od1_h[k] = od[1];
        end
        i0 = -1;
        for (int k = 1; k < 9; k++) begin
            if (i0 < 0 && sel_h[k] != sel_h[k-1]) i0 = k;
        end
        cmp("contention_sel_switch_seen", 0, 8'(i0 >= 0), 8'h01);
        if (i0 >= 0) begin
            for (int k = 0; k < 12; k++) begin
                cmp("contention_sel_period4", 0, 8'(sel_h[i0+k]), 8'(sel_h[i0] ^ ((k / 4) % 2 == 1)));
            end
        end
        for (int k = 4; k < 20; k++) begin
            cmp("burst1_alternate", 1, 8'(od1_h[k][7]), 8'(!od1_h[k-1][7]));
        end

        // backpressure: out_ready low for 3 cycles mid-stream
        for (int k = 0; k < 10; k++) begin
            do_cycle(2, !(k >= 2 && k <= 4));
            if (k == 2) held = od[0];
            if (k >= 2 && k <= 4) begin
                cmp("bp_a_ready", 0, 8'(ar[0]), 8'h00);
                cmp("bp_b_ready", 0, 8'(br[0]), 8'h00);
                cmp("bp_held",    0, od[0],     held);
            end
        end

        // source drop: A gives 2 beats, B stays valid
        for (int d = 0; d < 2; d++) seq[d][0] = 0;
        for (int k = 0; k < 12; k++) do_cycle(3, 1'b1);
        cmp("drop_grant_b", 0, 8'(sl[0]), 8'h01);

        // asynchronous reset in the middle of an active burst
        for (int k = 0; k < 3; k++) do_cycle(2, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            cmp("async_rst_sel",       d, 8'(sl[d]), 8'h00);
            cmp("async_rst_out_valid", d, 8'(ov[d]), 8'h00);
            cmp("async_rst_out_data",  d, od[d],     8'h00);
            cmp("async_rst_a_ready",   d, 8'(ar[d]), 8'h00);
            cmp("async_rst_b_ready",   d, 8'(br[d]), 8'h00);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic with random backpressure
        for (int k = 0; k < 600; k++) do_cycle(0, ($urandom_range(0, 3) != 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
